// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   rx_state_t : receiver FSM states (also visible on the top's state_dbg port)
//   *_MIN/_MAX : legal ranges for DATA_BITS and OVERSAMPLE
//   majority3  : 2-of-3 vote used for the bit decision
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: rx synchroniser, oversampling tick counter
// and 3-sample majority vote.
//   clk, rst   : clock, synchronous active-high reset
//   en         : low clears the tick counter
//   baud_tick  : oversampling tick (one clk pulse, may be held high)
//   rx         : asynchronous serial line, idle high
//   idle       : FSM is in IDLE (counter held at 0)
//   start      : FSM is taking the start-edge tick this cycle
//   rx_s       : synchronised rx
//   bit_val    : majority value of the current bit (meaningful with bit_decide)
//   bit_decide : pulse on the tick where tick_cnt = OVERSAMPLE/2 + 1
//   bit_end    : pulse on the tick where tick_cnt = OVERSAMPLE - 1
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic baud_tick,
  input  logic rx,
  input  logic idle,
  input  logic start,
  output logic rx_s,
  output logic bit_val,
  output logic bit_decide,
  output logic bit_end
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [TW-1:0] CNT_A    = TW'(M - 1);
  localparam logic [TW-1:0] CNT_B    = TW'(M);
  localparam logic [TW-1:0] CNT_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(OVERSAMPLE - 1);

  logic          rx_meta;
  logic [TW-1:0] tick_cnt;
  logic          samp_a;
  logic          samp_b;

  // Both flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The start-edge tick counts as tick 0 of the start bit, so the counter
  // leaves IDLE already at 1.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      tick_cnt <= '0;
    end else if (idle) begin
      tick_cnt <= start ? TW'(1) : '0;
    end else if (baud_tick) begin
      tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (!idle && baud_tick) begin
      if (tick_cnt == CNT_A) samp_a <= rx_s;
      if (tick_cnt == CNT_B) samp_b <= rx_s;
    end
  end

  // Third sample is taken live on the decision tick itself.
  assign bit_val    = majority3(samp_a, samp_b, rx_s);
  assign bit_decide = !idle && baud_tick && (tick_cnt == CNT_DEC);
  assign bit_end    = !idle && baud_tick && (tick_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, majority-voted, LSB-first.
//   clk, rst   : clock, synchronous active-high reset
//   en         : receiver enable, low forces IDLE
//   baud_tick  : oversampling tick at OVERSAMPLE x baud
//   rx         : asynchronous serial line, idle high
//   data_out   : last received payload, bit 0 = first data bit
//   data_valid : one-cycle frame-complete strobe
//   parity_err : parity mismatch of the last frame (held until next strobe)
//   frame_err  : a stop bit was sampled 0 (held until next strobe)
//   busy       : receiver is not in IDLE
//   state_dbg  : current FSM state
// Handshake: data_valid is a push-only strobe with no ready; data_out and the
// error flags are valid in the cycle data_valid is high and stay stable until
// the next strobe. The consumer must accept every strobe.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output rx_state_t            state_dbg
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  rx_state_t            state, state_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bad, par_bad_n;
  logic                 stop_bad, stop_bad_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 deliver;
  logic                 start_det;

  logic rx_s;
  logic bit_val;
  logic bit_decide;
  logic bit_end;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .baud_tick (baud_tick),
    .rx        (rx),
    .idle      (state == IDLE),
    .start     (start_det),
    .rx_s      (rx_s),
    .bit_val   (bit_val),
    .bit_decide(bit_decide),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_bad_n  = par_bad;
    stop_bad_n = stop_bad;
    stop_cnt_n = stop_cnt;
    deliver    = 1'b0;
    start_det  = 1'b0;

    case (state)
      IDLE: begin
        if (baud_tick && !rx_s) begin
          start_det  = 1'b1;
          state_n    = START;
          bit_cnt_n  = '0;
          par_bad_n  = 1'b0;
          stop_bad_n = 1'b0;
          stop_cnt_n = 1'b0;
        end
      end
      START: begin
        // A start bit that votes high was noise: drop it without a strobe.
        if (bit_decide && bit_val) begin
          state_n = IDLE;
        end else if (bit_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_decide) shift_n[bit_cnt] = bit_val;
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_decide && (bit_val != ((^shift) ^ PAR_ODD))) par_bad_n = 1'b1;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_decide) begin
          if (!bit_val) stop_bad_n = 1'b1;
          // Leave mid-way through the last stop bit so a start edge that
          // follows with zero idle time is still caught.
          if (stop_cnt == STOP_LAST) begin
            deliver = 1'b1;
            state_n = IDLE;
          end
        end else if (bit_end) begin
          stop_cnt_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Disable wins over any tick arriving in the same cycle.
    if (!en) begin
      state_n    = IDLE;
      bit_cnt_n  = '0;
      par_bad_n  = 1'b0;
      stop_bad_n = 1'b0;
      stop_cnt_n = 1'b0;
      deliver    = 1'b0;
      start_det  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      stop_cnt   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par_bad    <= par_bad_n;
      stop_bad   <= stop_bad_n;
      stop_cnt   <= stop_cnt_n;
      data_valid <= deliver;
      if (deliver) begin
        data_out   <= shift;
        parity_err <= par_bad;
        frame_err  <= stop_bad_n;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 7O2) share clk and
// baud_tick; each has its own rx/en. Frames are built from bit lists, the
// expected result is pushed when a frame is issued and a monitor pops it on
// every data_valid.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [2:0] en = 3'b111;
  logic [2:0] dv, pe, fe, bsy;
  logic [7:0] dout0, dout1;
  logic [6:0] dout2;
  rx_state_t  st0, st1, st2;

  bit  cont = 1'b1;
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];
  bit  lat_arm = 1'b0;
  bit  lat_seen = 1'b0;
  int  lat_t0 = 0;
  int  lat_exp = 0;

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (cont) baud_tick = 1'b1;
      else      baud_tick = ~baud_tick;
    end
  end

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .en(en[0]), .baud_tick(baud_tick), .rx(rx[0]),
    .data_out(dout0), .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .busy(bsy[0]), .state_dbg(st0));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .en(en[1]), .baud_tick(baud_tick), .rx(rx[1]),
    .data_out(dout1), .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .busy(bsy[1]), .state_dbg(st1));

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .en(en[2]), .baud_tick(baud_tick), .rx(rx[2]),
    .data_out(dout2), .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .busy(bsy[2]), .state_dbg(st2));

  // ---------------- instance configuration ----------------
  function automatic int cfg_bits(input int u);  return (u == 2) ? 7 : 8; endfunction
  function automatic int cfg_par(input int u);   return (u != 0) ? 1 : 0; endfunction
  function automatic int cfg_odd(input int u);   return (u == 2) ? 1 : 0; endfunction
  function automatic int cfg_stops(input int u); return (u == 2) ? 2 : 1; endfunction

  function automatic rx_state_t state_of(input int u);
    case (u)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int u, input logic [10:0] e);
    case (u)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // act/exp layout: {parity_err, frame_err, data[8:0]}
  task automatic check_frame(input int u, input logic [10:0] act, input logic b);
    logic [10:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (u)
      0: if (exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
      1: if (exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
      default: if (exp_q2.size() > 0) begin have = 1'b1; e = exp_q2.pop_front(); end
    endcase
    if (!have) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_strobe u%0d: got frame 0x%0h, expected no strobe", u, act);
    end else begin
      check($sformatf("u%0d data", u), 32'(act[8:0]), 32'(e[8:0]));
      check($sformatf("u%0d parity_err", u), 32'(act[10]), 32'(e[10]));
      check($sformatf("u%0d frame_err", u), 32'(act[9]), 32'(e[9]));
      check($sformatf("u%0d busy_at_strobe", u), 32'(b), 32'd0);
    end
  endtask

  // Monitor: every strobe is matched against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (dv[0]) begin
        check_frame(0, {pe[0], fe[0], 1'b0, dout0}, bsy[0]);
        if (lat_arm && !lat_seen) begin
          lat_seen = 1'b1;
          check("latency_8n1", cyc - lat_t0, lat_exp);
        end
      end
      if (dv[1]) check_frame(1, {pe[1], fe[1], 1'b0, dout1}, bsy[1]);
      if (dv[2]) check_frame(2, {pe[2], fe[2], 2'b00, dout2}, bsy[2]);
    end
  end

  // ---------------- drivers ----------------
  // Returns 1 time unit after the n-th tick edge from now.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic idle_line(input int u, input int n);
    rx[u] = 1'b1;
    if (n > 0) wait_ticks(n);
  endtask

  // Sends one frame on instance u. Caller is positioned just after a tick edge.
  // glitch_bit: frame bit index (0 = start) that gets a one-tick inversion mid-bit.
  // abort_bit : frame bit index where en is dropped (no strobe expected).
  task automatic send_frame(input int u, input logic [8:0] d, input bit bad_par,
                            input logic [1:0] stop_v, input int glitch_bit,
                            input int abort_bit, input bit lat);
    int nb, np, ns, odd, ones;
    logic [8:0] dm;
    logic pbit;
    logic bits[$];
    bit perr, ferr;
    nb = cfg_bits(u);
    np = cfg_par(u);
    ns = cfg_stops(u);
    odd = cfg_odd(u);
    dm = d & ((9'h1 << nb) - 9'h1);
    ones = $countones(dm);
    // Correct parity bit makes the total count of ones even (or odd).
    pbit = logic'((ones % 2) ^ odd) ^ bad_par;
    perr = (np != 0) && (((ones + int'(pbit)) % 2) != odd);
    ferr = (stop_v[0] == 1'b0) || (ns == 2 && stop_v[1] == 1'b0);
    if (abort_bit < 0) push_exp(u, {perr, ferr, dm});

    bits.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
    if (np != 0) bits.push_back(pbit);
    bits.push_back(stop_v[0]);
    if (ns == 2) bits.push_back(stop_v[1]);

    if (lat) begin
      lat_t0   = cyc;
      lat_exp  = 3 + OS * (nb + np + ns) + M + 1;
      lat_seen = 1'b0;
      lat_arm  = 1'b1;
    end

    foreach (bits[i]) begin
      if (i == abort_bit) begin
        en[u] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("u%0d busy_after_en_low", u), 32'(bsy[u]), 32'd0);
        check($sformatf("u%0d state_after_en_low", u), 32'(state_of(u)), 32'(IDLE));
        wait_ticks(1);
      end
      rx[u] = bits[i];
      if (i == glitch_bit) begin
        wait_ticks(M);
        rx[u] = ~bits[i];
        wait_ticks(1);
        rx[u] = bits[i];
        wait_ticks(OS - M - 1);
      end else begin
        wait_ticks(OS);
      end
    end
    rx[u] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int u, nb, ns, glitch, gap, tmo;
    logic [8:0] d;
    logic [1:0] sv;
    bit bp, seen, bad_stop;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset dout0", 32'(dout0), 32'd0);
    check("reset dout1", 32'(dout1), 32'd0);
    check("reset dout2", 32'(dout2), 32'd0);
    check("reset data_valid", 32'(dv), 32'd0);
    check("reset parity_err", 32'(pe), 32'd0);
    check("reset frame_err", 32'(fe), 32'd0);
    check("reset busy", 32'(bsy), 32'd0);
    check("reset state u0", 32'(st0), 32'(IDLE));

    // 8N1 0xA5 with continuous ticks and a latency check
    cont = 1'b1;
    wait_ticks(2);
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, -1, 1'b1);
    idle_line(0, 4);
    check("latency_measured", 32'(lat_seen), 32'd1);
    check("busy after 0xA5", 32'(bsy[0]), 32'd0);

    // Switch to one tick every two clocks
    cont = 1'b0;
    wait_ticks(3);

    // 8E1: wrong parity then right parity
    send_frame(1, 9'h03C, 1'b1, 2'b11, -1, -1, 1'b0);
    send_frame(1, 9'h03C, 1'b0, 2'b11, -1, -1, 1'b0);
    idle_line(1, 4);

    // 8N1 stop bit 0
    send_frame(0, 9'h05A, 1'b0, 2'b10, -1, -1, 1'b0);
    idle_line(0, 3 * OS);

    // False start: 4 ticks low
    rx[0] = 1'b0;
    wait_ticks(4);
    rx[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      wait_ticks(1);
      if (bsy[0]) seen = 1'b1;
    end
    check("false_start busy_seen", 32'(seen), 32'd1);
    check("false_start busy_low", 32'(bsy[0]), 32'd0);
    check("false_start state_idle", 32'(st0), 32'(IDLE));
    check("false_start dout_kept", 32'(dout0), 32'h5A);

    // Back-to-back 0x00 / 0xFF with single-tick glitches
    send_frame(0, 9'h000, 1'b0, 2'b11, 3, -1, 1'b0);
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 5, -1, 1'b0);
    idle_line(0, 4);

    // 7O2: 0x41, then a frame aborted by en in DATA
    send_frame(2, 9'h041, 1'b0, 2'b11, -1, -1, 1'b0);
    idle_line(2, 4);
    send_frame(2, 9'h02A, 1'b0, 2'b11, -1, 3, 1'b0);
    idle_line(2, 2 * OS);
    en[2] = 1'b1;
    wait_ticks(2);
    check("en_abort dout_kept", 32'(dout2), 32'h41);
    check("en_abort busy_low", 32'(bsy[2]), 32'd0);

    // Randomised frames
    for (int r = 0; r < 36; r++) begin
      if (r % 12 == 0) begin
        idle_line(0, 2);
        cont = ($urandom_range(0, 1) == 1);
        wait_ticks(2);
      end
      u  = $urandom_range(0, 2);
      nb = cfg_bits(u);
      ns = cfg_stops(u);
      d  = 9'($urandom_range(0, 511));
      bp = (cfg_par(u) != 0) && ($urandom_range(0, 3) == 0);
      sv = 2'b11;
      if ($urandom_range(0, 4) == 0) begin
        if (ns == 2) sv = 2'($urandom_range(0, 2));
        else         sv = 2'b10;
      end
      bad_stop = (sv[0] == 1'b0) || (ns == 2 && sv[1] == 1'b0);
      glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, nb)) : -1;
      send_frame(u, d, bp, sv, glitch, -1, 1'b0);
      gap = bad_stop ? 3 * OS : int'($urandom_range(0, 3));
      idle_line(u, gap);
    end

    // Drain
    tmo = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && tmo < 2000) begin
      @(posedge clk);
      tmo++;
    end
    check("drain q0", exp_q0.size(), 0);
    check("drain q1", exp_q1.size(), 0);
    check("drain q2", exp_q2.size(), 0);

    // Reset clears held outputs
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst clears dout2", 32'(dout2), 32'd0);
    check("rst clears flags", 32'({pe, fe}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: oversampled, majority-voted, LSB-first serial-to-parallel converter with configurable data width, optional parity and 1 or 2 stop bits. It sits between the pad-side `rx` line and the byte consumer, and is driven by the shared oversampling `baud_tick` generator. It reports every frame with a one-cycle valid strobe and parity/framing error flags.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal 5–9.
- `OVERSAMPLE`, 16: `baud_tick`s per bit, even, legal 8–32.
- `PARITY_EN`, 0: 1 = parity bit present after data.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even (ignored if `PARITY_EN`=0).
- `STOP_BITS`, 1: 1 or 2.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: receiver enable; low forces IDLE synchronously.
- `baud_tick` in 1: one-`clk` pulse at `OVERSAMPLE` × baud rate.
- `rx` in 1: asynchronous serial input, idle high.
- `data_out` out DATA_BITS: last received payload, LSB = first data bit.
- `data_valid` out 1: one-`clk` pulse, frame complete.
- `parity_err` out 1: valid with `data_valid`; parity mismatch.
- `frame_err` out 1: valid with `data_valid`; any stop bit sampled 0.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1) → `rx_s`. Only `rx_s` is used internally.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when `PARITY_EN`=0.
- `tick_cnt` (width clog2(`OVERSAMPLE`)) advances only on `baud_tick`; wraps `OVERSAMPLE`-1 → 0.
- IDLE: on a `baud_tick` with `rx_s`=0 → START, `tick_cnt`=0.
- Bit decision: `rx_s` is sampled on the ticks at `tick_cnt` = M-1, M and M+1 (M = `OVERSAMPLE`/2). The bit value is the 2-of-3 majority, decided on tick M+1.
- START: decision 1 → false start, return to IDLE on that tick with no strobe. Decision 0 → at `tick_cnt`=`OVERSAMPLE`-1, go to DATA with `bit_cnt`=0.
- DATA: decided bit is shifted in LSB-first at position `bit_cnt`. At end of bit, `bit_cnt`==`DATA_BITS`-1 → PARITY/STOP, otherwise `bit_cnt`+1.
- PARITY: compare the decided bit with XOR(data) XOR `PARITY_ODD`; a mismatch sets internal `par_bad`. At end of bit → STOP.
- STOP: each stop bit decision of 0 sets `stop_bad`. On the decision tick of the last stop bit:
  - update `data_out`
  - pulse `data_valid`
  - drive `parity_err`=`par_bad` and `frame_err`=`stop_bad`
  - go to IDLE immediately (mid-stop-bit) so the next start edge is caught.
- A frame error still delivers data.
- `en`=0 or `rst`: state → IDLE, counters and `par_bad`/`stop_bad` cleared, no strobe. `data_out` is retained on `en`=0 and cleared on `rst`.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
- Path from the `rx` pin to `rx_s` is 2 `clk`.
- `data_valid`, `data_out` and the error flags are registered and assert on the `clk` edge after the final stop-bit decision tick. The flags hold until the next `data_valid`.
- Frame latency is measured from the start-edge tick to `data_valid`:
  - ticks = `OVERSAMPLE`×(1+`DATA_BITS`+`PARITY_EN`+`STOP_BITS`-1) + M + 1
  - plus 1 `clk`.
- Back-to-back frames with zero idle time must be received.
- `baud_tick` coinciding with `en` falling: `en` wins.
- `baud_tick` held high continuously is legal; each `clk` counts as one tick.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP)
  - localparams for legal `DATA_BITS`/`OVERSAMPLE` ranges.
- Sub-module `uart_rx_sampler`:
  - contains the 2-flop synchronizer, `tick_cnt` and the 3-sample majority vote
  - outputs `bit_val`, `bit_decide` (pulse on tick M+1) and `bit_end` (pulse on tick `OVERSAMPLE`-1).
- The FSM, shift register and output registers live in the top.

## Test plan
- 8N1, `OVERSAMPLE`=16, send 0xA5 → one `data_valid`, `data_out`=0xA5, both error flags 0, `busy` low after the strobe.
- 8E1, send 0x3C with parity bit 1 (wrong) → `data_out`=0x3C, `parity_err`=1, `frame_err`=0; next frame 0x3C with parity 0 → `parity_err`=0.
- 8N1, send 0x5A with stop bit 0 → `data_out`=0x5A, `frame_err`=1.
- `rx` low for 4 ticks, then high → no `data_valid`, state returns to IDLE, `busy` pulses only during the glitch.
- Back-to-back 0x00 then 0xFF with no idle time → two strobes, values 0x00 and 0xFF, no errors; a single-tick glitch mid-bit (majority vote) does not alter either value.
- `DATA_BITS`=7, `STOP_BITS`=2, `PARITY_EN`=1, `PARITY_ODD`=1, send 0x41:
  - `data_out`=0x41, no errors.
  - Deassert `en` during DATA of the next frame → no strobe, `data_out` stays 0x41, `busy`=0 the cycle after.
